ppm_phase_detector_gen: RTL and testbench

Parametrised second-generation early/late phase detector for the oversampled PPM receive path. It counts ones per slot of OSR oversampled ppmdata bits and decides whether the local slot clock is ahead of or behind the received pulse edge. It adds a signed phase-error output, an optional vote filter and a lock indicator. It sits between the oversampling front end and the slot-clock adjust logic, and its ahead/behind outputs drive the clock-adjust inputs as the gen-1 detector's did.

---
 rtl/ppm_phase_detector_gen_if.sv | 25 ++
 rtl/ppm_phase_detector_gen.sv | 169 ++++++++++++++++
 tb/tb_ppm_phase_detector_gen.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ppm_phase_detector_gen_if.sv
// Signal bundle between the oversampling front end and the gen-2 phase detector.
// The master drives the samples and mode. The slave returns the decisions and lock.
interface ppm_phase_detector_gen_if #(
  parameter int unsigned CNT_W = 4
);
  logic                    sample_valid;
  logic                    slot_start;
  logic                    ppmdata;
  logic                    mode;
  logic                    ahead;
  logic                    behind;
  logic                    err_valid;
  logic signed [CNT_W-1:0] phase_err;
  logic                    lock;

  modport master (
    output sample_valid, slot_start, ppmdata, mode,
    input  ahead, behind, err_valid, phase_err, lock
  );

  modport slave (
    input  sample_valid, slot_start, ppmdata, mode,
    output ahead, behind, err_valid, phase_err, lock
  );
endinterface

// File: rtl/ppm_phase_detector_gen.sv
// Early/late phase detector for the oversampled PPM path. It counts ones per slot and
// emits ahead/behind pulses, a signed phase error, an optional vote filter and lock.
module ppm_phase_detector_gen #(
  parameter int unsigned OSR        = 8,
  parameter int unsigned CNT_W      = $clog2(OSR) + 1,
  parameter int unsigned VOTE_DEPTH = 4,
  parameter int unsigned LOCK_CNT   = 16
) (
  input logic                     clk_high,
  input logic                     rst,
  ppm_phase_detector_gen_if.slave bus
);

  localparam int unsigned IdxW  = $clog2(OSR);
  localparam int unsigned VoteW = 5;
  localparam int unsigned LockW = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] OsrC    = CNT_W'(OSR);
  localparam logic [CNT_W-1:0] HalfC   = CNT_W'(OSR / 2);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(OSR - 1);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_CNT);

  localparam logic signed [VoteW-1:0] VoteMax = VoteW'(VOTE_DEPTH);
  localparam logic signed [VoteW-1:0] VoteMin = -VoteMax;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StAcc  = 1'b1;

  logic [0:0]              st_q, st_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]        sum_q, sum_d;
  logic [CNT_W-1:0]        prev_q, prev_d;
  logic                    first_q, first_d;
  logic signed [VoteW-1:0] vote_q, vote_d;
  logic [LockW-1:0]        lock_cnt_q, lock_cnt_d;
  logic                    mode_q;
  logic                    ahead_q, ahead_d;
  logic                    behind_q, behind_d;
  logic                    err_valid_q, err_valid_d;
  logic [CNT_W-1:0]        phase_err_q, phase_err_d;

  logic [CNT_W-1:0]        slot_sum;
  logic [CNT_W-1:0]        mag;
  logic                    is_low, is_high, is_ahead, is_behind;
  logic signed [VoteW-1:0] vote_step, vote_next;
  logic                    slot_begin;

  // Slot evaluation always includes the bit arriving this cycle.
  assign slot_sum  = sum_q + {{(CNT_W-1){1'b0}}, bus.ppmdata};
  assign is_low    = (slot_sum != '0) && (slot_sum < HalfC);
  assign is_high   = (slot_sum > HalfC) && (slot_sum < OsrC);
  assign is_ahead  = (is_low && !first_q) || (is_high && first_q) ||
                     ((slot_sum == OsrC) && (prev_q == '0)) ||
                     ((slot_sum == '0) && (prev_q == OsrC));
  assign is_behind = (is_low && first_q) || (is_high && !first_q);
  assign mag       = is_low   ? slot_sum        :
                     is_high  ? OsrC - slot_sum :
                     is_ahead ? HalfC           : '0;
  assign vote_step = is_ahead ? 5'sd1 : (is_behind ? -5'sd1 : 5'sd0);

  // Sample 0 is an explicit slot_start or the free-running wrap after a decision.
  assign slot_begin = bus.slot_start || ((st_q == StAcc) && (idx_q == '0));

  always_comb begin
    st_d        = st_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    prev_d      = prev_q;
    first_d     = first_q;
    vote_d      = vote_q;
    lock_cnt_d  = lock_cnt_q;
    ahead_d     = 1'b0;
    behind_d    = 1'b0;
    err_valid_d = 1'b0;
    phase_err_d = phase_err_q;
    vote_next   = '0;

    if (ahead_q || behind_q) begin
      lock_cnt_d = '0;
    end
    if (bus.mode != mode_q) begin
      vote_d = '0;
    end

    if (!bus.sample_valid) begin
      st_d        = StIdle;
      idx_d       = '0;
      sum_d       = '0;
      vote_d      = '0;
      lock_cnt_d  = '0;
      prev_d      = HalfC;
      phase_err_d = '0;
    end else if (slot_begin) begin
      // A slot_start with idx != 0 discards the partial slot.
      st_d    = StAcc;
      first_d = bus.ppmdata;
      sum_d   = {{(CNT_W-1){1'b0}}, bus.ppmdata};
      idx_d   = IdxW'(1);
    end else if (st_q == StAcc) begin
      if (idx_q == IdxLast) begin
        idx_d       = '0;
        sum_d       = '0;
        prev_d      = slot_sum;
        err_valid_d = 1'b1;
        phase_err_d = is_behind ? -mag : mag;
        if (!bus.mode) begin
          ahead_d  = is_ahead;
          behind_d = is_behind;
        end else begin
          vote_next = vote_d + vote_step;
          if (vote_next == VoteMax) begin
            ahead_d = 1'b1;
            vote_d  = '0;
          end else if (vote_next == VoteMin) begin
            behind_d = 1'b1;
            vote_d   = '0;
          end else begin
            vote_d = vote_next;
          end
        end
        if (!ahead_d && !behind_d && (lock_cnt_d != LockMax)) begin
          lock_cnt_d = lock_cnt_d + LockW'(1);
        end
      end else begin
        sum_d = slot_sum;
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk_high) begin
    if (rst) begin
      st_q        <= StIdle;
      idx_q       <= '0;
      sum_q       <= '0;
      prev_q      <= HalfC;
      first_q     <= 1'b0;
      vote_q      <= '0;
      lock_cnt_q  <= '0;
      mode_q      <= 1'b0;
      ahead_q     <= 1'b0;
      behind_q    <= 1'b0;
      err_valid_q <= 1'b0;
      phase_err_q <= '0;
    end else begin
      st_q        <= st_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      vote_q      <= vote_d;
      lock_cnt_q  <= lock_cnt_d;
      mode_q      <= bus.mode;
      ahead_q     <= ahead_d;
      behind_q    <= behind_d;
      err_valid_q <= err_valid_d;
      phase_err_q <= phase_err_d;
    end
  end

  assign bus.ahead     = ahead_q;
  assign bus.behind    = behind_q;
  assign bus.err_valid = err_valid_q;
  assign bus.phase_err = phase_err_q;
  assign bus.lock      = (lock_cnt_q == LockMax);

  a_exclusive_pulse : assert property (@(posedge clk_high) !(ahead_q && behind_q));

endmodule

// File: tb/tb_ppm_phase_detector_gen.sv
// Bench for ppm_phase_detector_gen: a table of slot vectors, hand-written disturbance
// sequences and a random phase. A queue-based slot model checks every cycle.
module tb_ppm_phase_detector_gen;
  localparam int OSR   = 8;
  localparam int CNT_W = $clog2(OSR) + 1;
  localparam int VD    = 4;
  localparam int LC    = 16;
  localparam int H     = OSR / 2;

  logic clk_high = 1'b0;
  logic rst      = 1'b1;

  ppm_phase_detector_gen_if #(.CNT_W(CNT_W)) bus ();

  ppm_phase_detector_gen #(
    .OSR        (OSR),
    .CNT_W      (CNT_W),
    .VOTE_DEPTH (VD),
    .LOCK_CNT   (LC)
  ) dut (
    .clk_high (clk_high),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_high = ~clk_high;

  int checks = 0;
  int errors = 0;

  // Reference model: a slot is the queue of samples since sample 0.
  bit m_q[$];
  bit m_active, m_mode, m_a, m_b, m_ev;
  int m_prev, m_vote, m_lock, m_pe;

  typedef struct {
    logic [7:0] bits;   // bits[7] is sample 0
    bit         md;
    bit         e_a;
    bit         e_b;
    int         e_pe;
    bit         e_lock;
  } vec_t;
  vec_t tv[$];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(bit r, bit sv, bit ss, bit d, bit md);
    int s, cls, mag;
    bit f, pa, pb, pulse_last;
    if (r) begin
      m_q.delete();
      m_active = 0; m_mode = 0; m_a = 0; m_b = 0; m_ev = 0;
      m_prev = H; m_vote = 0; m_lock = 0; m_pe = 0;
      return;
    end
    pulse_last = m_a | m_b;
    m_a = 0; m_b = 0; m_ev = 0;
    if (pulse_last) m_lock = 0;
    if (md != m_mode) m_vote = 0;
    m_mode = md;
    if (!sv) begin
      m_q.delete();
      m_active = 0; m_vote = 0; m_lock = 0; m_prev = H; m_pe = 0;
      return;
    end
    if (ss) begin
      m_q.delete();
      m_q.push_back(d);
      m_active = 1;
      return;
    end
    if (!m_active) return;
    m_q.push_back(d);
    if (m_q.size() < OSR) return;
    s = 0;
    foreach (m_q[i]) s += m_q[i];
    f = m_q[0];
    m_q.delete();
    if (s > 0 && s < H) begin
      cls = f ? -1 : 1; mag = s;
    end else if (s > H && s < OSR) begin
      cls = f ? 1 : -1; mag = OSR - s;
    end else if ((s == OSR && m_prev == 0) || (s == 0 && m_prev == OSR)) begin
      cls = 1; mag = H;
    end else begin
      cls = 0; mag = 0;
    end
    m_prev = s;
    m_ev = 1;
    m_pe = cls * mag;
    pa = 0; pb = 0;
    if (!md) begin
      pa = (cls == 1); pb = (cls == -1);
    end else begin
      m_vote += cls;
      if (m_vote >= VD) begin pa = 1; m_vote = 0; end
      else if (m_vote <= -VD) begin pb = 1; m_vote = 0; end
    end
    m_a = pa; m_b = pb;
    if (!pa && !pb && m_lock < LC) m_lock++;
  endtask

  task automatic drive(bit sv, bit ss, bit d, bit md);
    int pe;
    bus.sample_valid = sv;
    bus.slot_start   = ss;
    bus.ppmdata      = d;
    bus.mode         = md;
    @(posedge clk_high);
    model_step(rst, sv, ss, d, md);
    #1;
    pe = bus.phase_err;
    check("model ahead", bus.ahead, m_a);
    check("model behind", bus.behind, m_b);
    check("model err_valid", bus.err_valid, m_ev);
    check("model phase_err", pe, m_pe);
    check("model lock", bus.lock, (m_lock == LC) ? 1 : 0);
  endtask

  task automatic slot(logic [7:0] bits, bit md, bit ss);
    for (int i = 0; i < OSR; i++) drive(1'b1, ss && (i == 0), bits[7 - i], md);
  endtask

  task automatic check_decision(string name, bit ea, bit eb, int epe);
    int pe;
    pe = bus.phase_err;
    check({name, " err_valid"}, bus.err_valid, 1);
    check({name, " ahead"}, bus.ahead, ea);
    check({name, " behind"}, bus.behind, eb);
    check({name, " phase_err"}, pe, epe);
  endtask

  initial begin
    int pe, bias;
    logic [7:0] rbits;

    // bits, md, ahead, behind, phase_err, lock
    tv.push_back('{8'b00011111, 0, 0, 1, -3, 0});
    tv.push_back('{8'b00000011, 0, 1, 0,  2, 0});
    tv.push_back('{8'b11110000, 0, 0, 0,  0, 0});
    tv.push_back('{8'b00000000, 0, 0, 0,  0, 0});
    tv.push_back('{8'b11111111, 0, 1, 0,  4, 0});
    tv.push_back('{8'b11111111, 0, 0, 0,  0, 0});
    tv.push_back('{8'b00000000, 0, 1, 0,  4, 0});
    tv.push_back('{8'b11100000, 0, 0, 1, -3, 0});
    tv.push_back('{8'b01111111, 0, 0, 1, -1, 0});
    tv.push_back('{8'b10000000, 0, 0, 1, -1, 0});
    tv.push_back('{8'b11111110, 0, 1, 0,  1, 0});
    tv.push_back('{8'b01000000, 0, 1, 0,  1, 0});
    tv.push_back('{8'b00000011, 1, 0, 0,  2, 0});
    tv.push_back('{8'b00000011, 1, 0, 0,  2, 0});
    tv.push_back('{8'b00000011, 1, 0, 0,  2, 0});
    tv.push_back('{8'b00011111, 1, 0, 0, -3, 0});
    tv.push_back('{8'b00000011, 1, 0, 0,  2, 0});
    tv.push_back('{8'b00000011, 1, 1, 0,  2, 0});
    for (int i = 0; i < 4; i++) tv.push_back('{8'b00011111, 1, 0, (i == 3), -3, 0});
    for (int i = 0; i < 16; i++) tv.push_back('{8'b11110000, 0, 0, 0, 0, (i == 15)});
    tv.push_back('{8'b00000011, 0, 1, 0, 2, 1});

    bus.sample_valid = 0; bus.slot_start = 0; bus.ppmdata = 0; bus.mode = 0;
    rst = 1;
    drive(0, 0, 0, 0);
    drive(1, 1, 1, 0);
    pe = bus.phase_err;
    check("reset ahead", bus.ahead, 0);
    check("reset behind", bus.behind, 0);
    check("reset err_valid", bus.err_valid, 0);
    check("reset phase_err", pe, 0);
    check("reset lock", bus.lock, 0);
    rst = 0;

    foreach (tv[r]) begin
      slot(tv[r].bits, tv[r].md, r == 0);
      check_decision($sformatf("vec%0d", r), tv[r].e_a, tv[r].e_b, tv[r].e_pe);
      check($sformatf("vec%0d lock", r), bus.lock, tv[r].e_lock);
    end
    drive(1, 0, 1, 0);
    check("lock after pulse", bus.lock, 0);

    // Resync at idx=5: partial slot dropped, decision 8 samples after the resync.
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 0);
    check("resync pre err_valid", bus.err_valid, 0);
    for (int i = 0; i < OSR; i++) begin
      drive(1, i == 0, (i >= 6), 0);
      if (i < OSR - 1) check($sformatf("resync gap%0d err_valid", i), bus.err_valid, 0);
    end
    check_decision("resync", 1, 0, 2);

    // sample_valid drop clears lock and vote; no decision until the next slot_start.
    for (int i = 0; i < LC; i++) slot(8'b11110000, 0, 0);
    check("lock up", bus.lock, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    check("sv drop lock", bus.lock, 0);
    check("sv drop err_valid", bus.err_valid, 0);
    for (int i = 0; i < 2 * OSR; i++) begin
      drive(1, 0, i[0], 0);
      check($sformatf("sv idle%0d err_valid", i), bus.err_valid, 0);
    end
    for (int i = 0; i < 3; i++) slot(8'b00000011, 1, i == 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 1);
    drive(0, 0, 0, 1);
    slot(8'b00000011, 1, 1);
    check_decision("vote cleared", 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      slot(8'b00000011, 1, 0);
      check($sformatf("vote refill%0d ahead", i), bus.ahead, (i == 2));
    end

    // rst on the cycle that would otherwise complete the slot.
    slot(8'b00000011, 0, 1);
    check_decision("pre-rst", 1, 0, 2);
    for (int i = 0; i < OSR - 1; i++) drive(1, 0, 1, 0);
    rst = 1;
    drive(1, 0, 1, 0);
    rst = 0;
    pe = bus.phase_err;
    check("rst err_valid", bus.err_valid, 0);
    check("rst ahead", bus.ahead, 0);
    check("rst phase_err", pe, 0);
    slot(8'b11111111, 0, 1);
    check_decision("post-rst all-1", 0, 0, 0);

    // Randomized traffic with per-slot density so every slot class shows up.
    bias = 0;
    rbits = '0;
    for (int c = 0; c < 1500; c++) begin
      if (c % OSR == 0) bias = $urandom_range(0, OSR);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) rbits[0] = ~rbits[0];
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, OSR - 1) < bias, rbits[0]);
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
